// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the prio_enc_stream slice.
package prio_enc_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam int MODE_SCAN = 0;
  localparam int MODE_PRIO = 1;

  localparam bit DIR_LSB = 1'b0;
  localparam bit DIR_MSB = 1'b1;

  // Index width for an n-bit vector; never narrower than one bit.
  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_ffs.sv
// Combinational find-first-set: lowest (DIR_LSB) or highest (DIR_MSB) set bit.
module prio_enc_ffs
  import prio_enc_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = index_width(IN_W),
  parameter bit MSB_FIRST = DIR_LSB
) (
  input  logic [IN_W-1:0]  vec,
  output logic [OUT_W-1:0] index,
  output logic             found
);

  // Ascending scan: LSB order keeps the first hit, MSB order keeps the last.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (vec[i] && (MSB_FIRST || !found)) begin
        index = OUT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_stream.sv
// Streaming priority encoder: captures a request vector and emits the index
// of each set bit LSB first (MODE_SCAN) or only the highest one (MODE_PRIO).
// Optional out_remaining popcount port: define PRIO_ENC_COUNT_EN.
module prio_enc_stream
  import prio_enc_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = index_width(IN_W),
  parameter int MODE  = MODE_SCAN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_index,
  output logic             out_last,
  output logic             out_none
`ifdef PRIO_ENC_COUNT_EN
  ,
  output logic [OUT_W:0]   out_remaining
`endif
);

  state_t            state, state_next;
  logic [IN_W-1:0]   remaining, remaining_next;
  logic              none_flag, none_next;
  logic [OUT_W-1:0]  scan_index, top_index;
  logic              scan_found, top_found;
  logic [IN_W-1:0]   rem_low_cleared;
  logic [IN_W-1:0]   top_onehot;
  logic              accept, advance;

  prio_enc_ffs #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (DIR_LSB)
  ) u_scan (
    .vec   (remaining),
    .index (scan_index),
    .found (scan_found)
  );

  prio_enc_ffs #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (DIR_MSB)
  ) u_top (
    .vec   (in_data),
    .index (top_index),
    .found (top_found)
  );

  assign rem_low_cleared = remaining & (remaining - IN_W'(1));
  assign top_onehot      = IN_W'(1) << top_index;

  assign in_ready  = (state == IDLE) && enable && !reset;
  assign out_valid = (state == EMIT);
  // remaining is all-zero in IDLE and on a none beat, so the scan reads 0 there.
  assign out_index = scan_index;
  assign out_last  = out_valid && (none_flag || (scan_found && (rem_low_cleared == '0)));
  assign out_none  = out_valid && none_flag;

  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready && enable;

`ifdef PRIO_ENC_COUNT_EN
  assign out_remaining = (OUT_W+1)'($countones(remaining));
`endif

  // Next-state: capture in IDLE, retire one set bit per accepted beat in EMIT.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    none_next      = none_flag;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EMIT;
          none_next  = !top_found;
          if (MODE == MODE_PRIO) begin
            remaining_next = top_found ? top_onehot : '0;
          end else begin
            remaining_next = in_data;
          end
        end
      end
      EMIT: begin
        if (advance) begin
          remaining_next = rem_low_cleared;
          if (out_last) begin
            state_next = IDLE;
            none_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      none_flag <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      none_flag <= none_next;
    end
  end

endmodule
